// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor, adder).
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } serial_state_t;

    // Bit-counter width for a WIDTH-bit serial operation; never below one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Full subtractor built from two half subtractors: d = a - b - bin.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs_ab (
        .a    (a),
        .b    (b),
        .d    (d1),
        .bout (b1)
    );

    half_subtractor u_hs_bin (
        .a    (d1),
        .b    (bin),
        .d    (d),
        .bout (b2)
    );

    assign bout = b1 | b2;

endmodule

// File: rtl/half_subtractor.sv
// Half subtractor: d = a - b, bout set when b exceeds a.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bout
);

    assign d    = a ^ b;
    assign bout = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per cycle, LSB first.
//
// state | meaning
// IDLE  | waiting for start
// BUSY  | processing one bit per cycle, cnt = bit index
// DONE  | one-cycle result strobe; a new start is accepted here too
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    serial_state_t state_q;
    serial_state_t state_d;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Holds the WIDTH-1 bits already produced; the final bit joins on the last edge.
    logic [WIDTH-2:0] res;
    logic [WIDTH-1:0] res_next;
    logic             br;
    logic [CW-1:0]    cnt;

    logic load;
    logic shift;
    logic last;
    logic d_bit;
    logic br_next;

    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_next)
    );

    assign res_next = {d_bit, res};

    // Next-state and datapath control decode.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                shift = 1'b1;
                if (cnt == CNT_LAST) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture, per-bit shifting and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            a_sh <= a;
            b_sh <= b;
            br   <= borrow_in;
            cnt  <= '0;
        end else if (shift) begin
            a_sh <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh <= {1'b0, b_sh[WIDTH-1:1]};
            res  <= res_next[WIDTH-1:1];
            br   <= br_next;
            // Return to zero on the last bit so the counter never wraps past its range.
            cnt  <= last ? '0 : cnt + 1'b1;
        end
    end

    // Registered outputs; the result only moves on the transition into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff       <= '0;
            borrow_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (last) begin
                diff       <= res_next;
                borrow_out <= br_next;
            end
            busy <= (state_d == BUSY);
            done <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=2, plus a half_subtractor truth table.
module tb_serial_subtractor;

    typedef struct {
        logic [32:0] val;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // WIDTH=8 instance
    logic       rst8 = 1'b1, start8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic       borrow8, busy8, done8;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst        (rst8),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .borrow_in  (bin8),
        .diff       (diff8),
        .borrow_out (borrow8),
        .busy       (busy8),
        .done       (done8)
    );

    // WIDTH=2 instance
    logic       rst2 = 1'b1, start2 = 1'b0, bin2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0, diff2;
    logic       borrow2, busy2, done2;

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk        (clk),
        .rst        (rst2),
        .start      (start2),
        .a          (a2),
        .b          (b2),
        .borrow_in  (bin2),
        .diff       (diff2),
        .borrow_out (borrow2),
        .busy       (busy2),
        .done       (done2)
    );

    // Half subtractor truth table
    logic hs_a = 1'b0, hs_b = 1'b0, hs_d, hs_bout;

    half_subtractor u_hs (
        .a    (hs_a),
        .b    (hs_b),
        .d    (hs_d),
        .bout (hs_bout)
    );

    exp_t q8[$];
    exp_t q2[$];
    logic [8:0] held8 = '0;
    logic [2:0] held2 = '0;
    logic mon_en = 1'b0;
    int   ndone8 = 0;
    int   run8 = 0, run2 = 0;
    logic pdone8 = 1'b0, pdone2 = 1'b0;

    // Scoreboard monitor for the 8-bit instance.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (done8) begin
                exp_t e;
                ndone8++;
                check("done8_width", 33'(pdone8), 33'd0);
                check("busy8_len", 33'(run8), 33'd8);
                if (q8.size() == 0) begin
                    check("done8_unexpected", 33'd1, 33'd0);
                end else begin
                    e = q8.pop_front();
                    check("diff8", 33'(diff8), 33'(e.val[7:0]));
                    check("borrow8", 33'(borrow8), 33'(e.val[8]));
                    check("latency8", 33'(cyc - e.acc), 33'd8);
                    held8 = e.val[8:0];
                end
            end else begin
                check("hold8", 33'({borrow8, diff8}), 33'(held8));
            end
            run8   = busy8 ? run8 + 1 : 0;
            pdone8 = done8;
        end
    end

    // Scoreboard monitor for the 2-bit instance.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (done2) begin
                exp_t e;
                check("done2_width", 33'(pdone2), 33'd0);
                check("busy2_len", 33'(run2), 33'd2);
                if (q2.size() == 0) begin
                    check("done2_unexpected", 33'd1, 33'd0);
                end else begin
                    e = q2.pop_front();
                    check("res2", 33'({borrow2, diff2}), 33'(e.val[2:0]));
                    check("latency2", 33'(cyc - e.acc), 33'd2);
                    held2 = e.val[2:0];
                end
            end else begin
                check("hold2", 33'({borrow2, diff2}), 33'(held2));
            end
            run2   = busy2 ? run2 + 1 : 0;
            pdone2 = done2;
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        exp_t e;
        logic [8:0] r;
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        r = {1'b0, a} - {1'b0, b} - 9'(bin);
        e.val = 33'(r);
        e.acc = cyc + 1;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic bin);
        exp_t e;
        logic [2:0] r;
        @(negedge clk);
        a2 = a; b2 = b; bin2 = bin; start2 = 1'b1;
        r = {1'b0, a} - {1'b0, b} - 3'(bin);
        e.val = 33'(r);
        e.acc = cyc + 1;
        q2.push_back(e);
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic drain8();
        for (int i = 0; i < 60 && q8.size() != 0; i++) @(negedge clk);
        check("drain8", 33'(q8.size()), 33'd0);
    endtask

    task automatic drain2();
        for (int i = 0; i < 20 && q2.size() != 0; i++) @(negedge clk);
        check("drain2", 33'(q2.size()), 33'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   d0;
        int   c0;
        exp_t e;
        logic [1:0] v;

        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            hs_a = v[1];
            hs_b = v[0];
            #1;
            check("hs_d", 33'(hs_d), 33'(v[1] ^ v[0]));
            check("hs_bout", 33'(hs_bout), 33'(!v[1] && v[0]));
        end

        repeat (3) @(negedge clk);
        rst8 = 1'b0;
        rst2 = 1'b0;
        check("rst_diff8", 33'(diff8), 33'd0);
        check("rst_borrow8", 33'(borrow8), 33'd0);
        check("rst_busy8", 33'(busy8), 33'd0);
        check("rst_done8", 33'(done8), 33'd0);
        check("rst_res2", 33'({borrow2, diff2, busy2, done2}), 33'd0);
        mon_en = 1'b1;

        op8(8'h05, 8'h03, 1'b0); drain8();
        op8(8'h03, 8'h05, 1'b0); drain8();
        op8(8'h00, 8'h00, 1'b1); drain8();
        op8(8'h80, 8'h01, 1'b0); drain8();

        // A start pulse during BUSY must be ignored.
        d0 = ndone8;
        op8(8'h10, 8'h01, 1'b0);
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        drain8();
        repeat (12) @(negedge clk);
        check("ignored_start_dones", 33'(ndone8 - d0), 33'd1);

        // Start held high: one accept every WIDTH+1 cycles.
        @(negedge clk);
        a8 = 8'h20; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        c0 = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            e.val = 33'h01F;
            e.acc = c0 + 9 * k;
            q8.push_back(e);
        end
        repeat (19) @(negedge clk);
        start8 = 1'b0;
        drain8();
        repeat (4) @(negedge clk);

        // Reset in the middle of an operation.
        d0 = ndone8;
        op8(8'h55, 8'h22, 1'b0);
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        q8.delete();
        held8 = '0;
        @(negedge clk);
        rst8 = 1'b0;
        check("midrst_busy8", 33'(busy8), 33'd0);
        check("midrst_done8", 33'(done8), 33'd0);
        check("midrst_diff8", 33'(diff8), 33'd0);
        repeat (12) @(negedge clk);
        check("midrst_no_done", 33'(ndone8 - d0), 33'd0);
        op8(8'h09, 8'h04, 1'b0); drain8();

        // WIDTH=2 exhaustive.
        for (int i = 0; i < 32; i++) begin
            logic [4:0] s;
            s = 5'(i);
            op2(s[4:3], s[2:1], s[0]);
            drain2();
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
